// File: rtl/tinyml_pkg.sv
// Shared types for the tinyml datapath: tile payload width, tile type and
// the tile buffer control states.
package tinyml_pkg;

   localparam int unsigned TILE_WIDTH = 256;

   typedef logic [TILE_WIDTH-1:0] tile_t;

   typedef enum logic [1:0] {
      EMPTY   = 2'd0,
      FILLING = 2'd1,
      READY   = 2'd2
   } tile_buf_state_t;

endpackage

// File: rtl/tile_ram.sv
// Simple dual-port tile storage: one synchronous write port, one registered
// read port with read-before-write behaviour. The array is never reset.
module tile_ram #(
   parameter int unsigned TILE_WIDTH = 256,
   parameter int unsigned DEPTH      = 16,
   localparam int unsigned ADDR_W    = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_W-1:0]     waddr,
   input  logic [TILE_WIDTH-1:0] wdata,
   input  logic                  re,
   input  logic [ADDR_W-1:0]     raddr,
   output logic [TILE_WIDTH-1:0] rdata
);

   logic [TILE_WIDTH-1:0] mem [DEPTH];
   logic [TILE_WIDTH-1:0] rdata_q;

   // Both ports sample on the same edge, so a same-index read sees old data.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata_q <= mem[raddr];
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/tile_buffer.sv
// Tile buffer between the DRAM tile loader and the compute stage: captures
// strobed tiles, flags a complete matrix, and serves registered tile reads.
module tile_buffer
   import tinyml_pkg::*;
#(
   parameter int unsigned TILE_WIDTH = tinyml_pkg::TILE_WIDTH,
   parameter int unsigned DEPTH      = 16,
   localparam int unsigned ADDR_W    = $clog2(DEPTH),
   localparam int unsigned CNT_W     = ADDR_W + 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [TILE_WIDTH-1:0] tile_in,
   input  logic                  tile_valid,
   input  logic                  load_done,
   input  logic                  clear,
   input  logic                  rd_en,
   input  logic [ADDR_W-1:0]     rd_addr,
   output logic [TILE_WIDTH-1:0] rd_data,
   output logic                  rd_valid,
   output logic [CNT_W-1:0]      tile_count,
   output logic                  full,
   output logic                  ready,
   output logic                  overflow
);

   tile_buf_state_t state_q, state_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic              overflow_q, overflow_d;
   logic              full_q, full_d;
   logic              ready_q, ready_d;
   logic              rd_valid_q, rd_valid_d;
   logic              zero_q, zero_d;
   logic              we_c;
   logic [ADDR_W-1:0] waddr_c;
   logic              rd_hit_c;
   logic [TILE_WIDTH-1:0] ram_rdata;

   // Fill control: clear wins over any strobe in the same cycle.
   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      wr_ptr_d   = wr_ptr_q;
      overflow_d = overflow_q;
      we_c       = 1'b0;
      waddr_c    = wr_ptr_q;
      if (clear) begin
         state_d    = EMPTY;
         count_d    = '0;
         wr_ptr_d   = '0;
         overflow_d = 1'b0;
      end else begin
         case (state_q)
            EMPTY, READY: begin
               if (tile_valid) begin
                  we_c       = 1'b1;
                  waddr_c    = '0;
                  count_d    = CNT_W'(1);
                  wr_ptr_d   = ADDR_W'(1);
                  overflow_d = 1'b0;
                  state_d    = load_done ? READY : FILLING;
               end
            end
            FILLING: begin
               if (tile_valid) begin
                  if (count_q < CNT_W'(DEPTH)) begin
                     we_c    = 1'b1;
                     count_d = count_q + CNT_W'(1);
                     // Pointer parks on the last slot rather than wrapping.
                     if (wr_ptr_q != ADDR_W'(DEPTH - 1)) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
                  end else begin
                     overflow_d = 1'b1;
                  end
               end
               if (load_done) state_d = READY;
            end
            default: state_d = EMPTY;
         endcase
      end
      full_d  = (count_d == CNT_W'(DEPTH));
      ready_d = (state_d == READY);
   end

   // Out-of-range reads return zero; zero_q also holds through idle cycles.
   always_comb begin
      rd_hit_c   = rd_en && ({1'b0, rd_addr} < count_q);
      rd_valid_d = rd_en;
      zero_d     = rd_en ? !rd_hit_c : zero_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= EMPTY;
         count_q    <= '0;
         wr_ptr_q   <= '0;
         overflow_q <= 1'b0;
         full_q     <= 1'b0;
         ready_q    <= 1'b0;
         rd_valid_q <= 1'b0;
         zero_q     <= 1'b1;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         wr_ptr_q   <= wr_ptr_d;
         overflow_q <= overflow_d;
         full_q     <= full_d;
         ready_q    <= ready_d;
         rd_valid_q <= rd_valid_d;
         zero_q     <= zero_d;
      end
   end

   tile_ram #(
      .TILE_WIDTH (TILE_WIDTH),
      .DEPTH      (DEPTH)
   ) u_ram (
      .clk   (clk),
      .we    (we_c),
      .waddr (waddr_c),
      .wdata (tile_in),
      .re    (rd_hit_c),
      .raddr (rd_addr),
      .rdata (ram_rdata)
   );

   assign rd_data    = zero_q ? '0 : ram_rdata;
   assign rd_valid   = rd_valid_q;
   assign tile_count = count_q;
   assign full       = full_q;
   assign ready      = ready_q;
   assign overflow   = overflow_q;

endmodule
